// File: rtl/ip_ram_arb_pkg.sv
// Shared definitions for the two-client RAM read arbiter.
//   - arb_state_e : arbiter FSM states
//   - CLIENT_A/B  : owner / round-robin pointer encoding
//   - TIMEOUT_DATA: byte returned when the controller never answers
//   - rr_pick     : round-robin grant decision
package ip_ram_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } arb_state_e;

    localparam logic CLIENT_A = 1'b0;
    localparam logic CLIENT_B = 1'b1;

    localparam logic [7:0] TIMEOUT_DATA = 8'hFF;

    // Pick the next owner. On a tie the client that was not served last wins.
    function automatic logic rr_pick(input logic pend_a, input logic pend_b, input logic last);
        if (pend_a && pend_b) begin
            return ~last;
        end else if (pend_b) begin
            return CLIENT_B;
        end else begin
            return CLIENT_A;
        end
    endfunction

endpackage

// File: rtl/ip_ram_read_arbiter_capture.sv
// Per-client request capture for ip_ram_read_arbiter (module ip_ram_req_capture).
// Turns a level-type rd into a single pending request and holds the reply.
//   clk, n_reset   : clock, asynchronous active-low reset
//   rd_i           : client read level
//   address_i      : client address, latched on the accepted rd rising edge
//   clr_i          : owner completion, clears the pending flag
//   load_data_i    : load data_i into the reply register and pulse rdata_en_o
//   data_i         : reply byte
//   pend_o         : request pending or in flight
//   address_o      : latched request address
//   rdata_o        : reply byte, held until the next completion
//   rdata_en_o     : 1-cycle reply-valid pulse
module ip_ram_req_capture #(
    parameter int unsigned ADDRESS_W = 22
) (
    input  logic                 clk,
    input  logic                 n_reset,
    input  logic                 rd_i,
    input  logic [ADDRESS_W-1:0] address_i,
    input  logic                 clr_i,
    input  logic                 load_data_i,
    input  logic [7:0]           data_i,
    output logic                 pend_o,
    output logic [ADDRESS_W-1:0] address_o,
    output logic [7:0]           rdata_o,
    output logic                 rdata_en_o
);

    logic                 rd_q;
    logic                 pend_q, pend_d;
    logic [ADDRESS_W-1:0] addr_q, addr_d;
    logic [7:0]           rdata_q, rdata_d;
    logic                 rdata_en_q, rdata_en_d;
    logic                 rd_rise;

    always_comb begin
        rd_rise    = rd_i & ~rd_q;
        pend_d     = pend_q;
        addr_d     = addr_q;
        rdata_d    = rdata_q;
        rdata_en_d = load_data_i;
        if (clr_i) begin
            pend_d = 1'b0;
        end
        // A new rd on the completion edge is taken: the slot frees at that very edge.
        if (rd_rise && (!pend_q || clr_i)) begin
            pend_d = 1'b1;
            addr_d = address_i;
        end
        if (load_data_i) begin
            rdata_d = data_i;
        end
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            rd_q       <= 1'b0;
            pend_q     <= 1'b0;
            addr_q     <= '0;
            rdata_q    <= 8'h00;
            rdata_en_q <= 1'b0;
        end else begin
            rd_q       <= rd_i;
            pend_q     <= pend_d;
            addr_q     <= addr_d;
            rdata_q    <= rdata_d;
            rdata_en_q <= rdata_en_d;
        end
    end

    assign pend_o     = pend_q;
    assign address_o  = addr_q;
    assign rdata_o    = rdata_q;
    assign rdata_en_o = rdata_en_q;

endmodule

// File: rtl/ip_ram_read_arbiter.sv
// Two-client round-robin read arbiter in front of the shared RAM/SDRAM controller.
// Client A (Kanji ROM) and client B (other ROM mappers) each get exactly one memory
// read per rd rising edge; a timeout forces an 8'hFF reply if the controller stalls.
//   n_reset, clk                          : asynchronous active-low reset, system clock
//   a_rd/a_address, b_rd/b_address        : client requests (level rd)
//   a_busy/b_busy                         : request pending or in flight
//   a_rdata/a_rdata_en, b_rdata/b_rdata_en: reply byte and 1-cycle valid pulse
//   mem_rd/mem_address                    : read strobe to the controller, held until accepted
//   mem_busy                              : controller busy; accept = mem_rd & ~mem_busy
//   mem_rdata/mem_rdata_en                : controller reply, honoured only while waiting
module ip_ram_read_arbiter
    import ip_ram_arb_pkg::*;
#(
    parameter int unsigned ADDRESS_W      = 22,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                 n_reset,
    input  logic                 clk,
    input  logic                 a_rd,
    input  logic [ADDRESS_W-1:0] a_address,
    output logic                 a_busy,
    output logic [7:0]           a_rdata,
    output logic                 a_rdata_en,
    input  logic                 b_rd,
    input  logic [ADDRESS_W-1:0] b_address,
    output logic                 b_busy,
    output logic [7:0]           b_rdata,
    output logic                 b_rdata_en,
    output logic                 mem_rd,
    output logic [ADDRESS_W-1:0] mem_address,
    input  logic                 mem_busy,
    input  logic [7:0]           mem_rdata,
    input  logic                 mem_rdata_en
);

    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

    arb_state_e           state_q, state_d;
    logic                 owner_q, owner_d;
    logic                 last_q, last_d;
    logic [7:0]           cnt_q, cnt_d;
    logic [ADDRESS_W-1:0] mem_addr_q, mem_addr_d;
    logic                 mem_rd_q, mem_rd_d;

    logic                 a_pend, b_pend;
    logic [ADDRESS_W-1:0] a_addr_lat, b_addr_lat;
    logic                 grant;
    logic                 done;
    logic [7:0]           done_data;
    logic                 done_a, done_b;

    ip_ram_req_capture #(
        .ADDRESS_W (ADDRESS_W)
    ) u_cap_a (
        .clk         (clk),
        .n_reset     (n_reset),
        .rd_i        (a_rd),
        .address_i   (a_address),
        .clr_i       (done_a),
        .load_data_i (done_a),
        .data_i      (done_data),
        .pend_o      (a_pend),
        .address_o   (a_addr_lat),
        .rdata_o     (a_rdata),
        .rdata_en_o  (a_rdata_en)
    );

    ip_ram_req_capture #(
        .ADDRESS_W (ADDRESS_W)
    ) u_cap_b (
        .clk         (clk),
        .n_reset     (n_reset),
        .rd_i        (b_rd),
        .address_i   (b_address),
        .clr_i       (done_b),
        .load_data_i (done_b),
        .data_i      (done_data),
        .pend_o      (b_pend),
        .address_o   (b_addr_lat),
        .rdata_o     (b_rdata),
        .rdata_en_o  (b_rdata_en)
    );

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        last_d     = last_q;
        cnt_d      = cnt_q;
        mem_addr_d = mem_addr_q;
        grant      = CLIENT_A;
        done       = 1'b0;
        done_data  = TIMEOUT_DATA;
        case (state_q)
            ST_IDLE: begin
                if (a_pend || b_pend) begin
                    grant      = rr_pick(a_pend, b_pend, last_q);
                    owner_d    = grant;
                    mem_addr_d = (grant == CLIENT_B) ? b_addr_lat : a_addr_lat;
                    state_d    = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (!mem_busy) begin
                    cnt_d   = 8'd0;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (mem_rdata_en) begin
                    done      = 1'b1;
                    done_data = mem_rdata;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    done      = 1'b1;
                    done_data = TIMEOUT_DATA;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
                if (done) begin
                    last_d  = owner_q;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        done_a   = done && (owner_q == CLIENT_A);
        done_b   = done && (owner_q == CLIENT_B);
        mem_rd_d = (state_d == ST_ISSUE);
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state_q    <= ST_IDLE;
            owner_q    <= CLIENT_A;
            last_q     <= CLIENT_B;  // so A wins the first tie
            cnt_q      <= 8'd0;
            mem_addr_q <= '0;
            mem_rd_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            last_q     <= last_d;
            cnt_q      <= cnt_d;
            mem_addr_q <= mem_addr_d;
            mem_rd_q   <= mem_rd_d;
        end
    end

    assign a_busy      = a_pend;
    assign b_busy      = b_pend;
    assign mem_rd      = mem_rd_q;
    assign mem_address = mem_addr_q;

endmodule

// File: tb/tb_ip_ram_read_arbiter.sv
module tb_ip_ram_read_arbiter;

    localparam int AW = 22;
    localparam int T  = 20;

    logic          clk = 1'b0;
    logic          n_reset;
    logic          a_rd, b_rd;
    logic [AW-1:0] a_address, b_address;
    logic          a_busy, b_busy, a_rdata_en, b_rdata_en;
    logic [7:0]    a_rdata, b_rdata;
    logic          mem_rd, mem_busy, mem_rdata_en;
    logic [AW-1:0] mem_address;
    logic [7:0]    mem_rdata;

    int vectors = 0;
    int errors  = 0;

    always #5 clk = ~clk;

    ip_ram_read_arbiter #(
        .ADDRESS_W      (AW),
        .TIMEOUT_CYCLES (T)
    ) dut (
        .n_reset      (n_reset),
        .clk          (clk),
        .a_rd         (a_rd),
        .a_address    (a_address),
        .a_busy       (a_busy),
        .a_rdata      (a_rdata),
        .a_rdata_en   (a_rdata_en),
        .b_rd         (b_rd),
        .b_address    (b_address),
        .b_busy       (b_busy),
        .b_rdata      (b_rdata),
        .b_rdata_en   (b_rdata_en),
        .mem_rd       (mem_rd),
        .mem_address  (mem_address),
        .mem_busy     (mem_busy),
        .mem_rdata    (mem_rdata),
        .mem_rdata_en (mem_rdata_en)
    );

    // ---------------- directed table ----------------
    typedef struct {
        logic          ard;
        logic [AW-1:0] aad;
        logic          brd;
        logic [AW-1:0] bad;
        logic          busy;
        logic          en;
        logic [7:0]    dat;
        logic          e_abusy;
        logic          e_bbusy;
        logic          e_aen;
        logic          e_ben;
        logic [7:0]    e_ard;
        logic [7:0]    e_brd;
        logic          e_mrd;
        logic [AW-1:0] e_maddr;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t v(input logic ard, input logic [AW-1:0] aad, input logic brd,
                               input logic [AW-1:0] bad, input logic busy, input logic en,
                               input logic [7:0] dat, input logic eab, input logic ebb,
                               input logic eae, input logic ebe, input logic [7:0] ear,
                               input logic [7:0] ebr, input logic emr,
                               input logic [AW-1:0] ema);
        vec_t r;
        r.ard = ard; r.aad = aad; r.brd = brd; r.bad = bad;
        r.busy = busy; r.en = en; r.dat = dat;
        r.e_abusy = eab; r.e_bbusy = ebb; r.e_aen = eae; r.e_ben = ebe;
        r.e_ard = ear; r.e_brd = ebr; r.e_mrd = emr; r.e_maddr = ema;
        return r;
    endfunction

    function automatic void show(input string name, input logic [7:0] ab, input logic [7:0] eb,
                                 input logic [7:0] ae, input logic [7:0] ee,
                                 input logic [7:0] ard, input logic [7:0] eard,
                                 input logic [7:0] brd, input logic [7:0] ebrd,
                                 input logic mr, input logic emr,
                                 input logic [AW-1:0] ma, input logic [AW-1:0] ema);
        $display("FAIL %s t=%0t busy{a,b} got %b want %b en{a,b} got %b want %b a_rdata got %h want %h b_rdata got %h want %h mem_rd got %b want %b mem_address got %h want %h",
                 name, $time, ab[1:0], eb[1:0], ae[1:0], ee[1:0], ard, eard, brd, ebrd,
                 mr, emr, ma, ema);
    endfunction

    // ---------------- reference model ----------------
    // Transaction view: a request is pending from its rd rise until its reply;
    // the single in-flight transaction is described by timestamps.
    logic [1:0]    m_pend, m_prev, m_en;
    logic [AW-1:0] m_addr [2];
    logic [7:0]    m_rdata [2];
    int            m_last;
    bit            tx_active, tx_accepted;
    int            tx_owner, tx_accept_edge, edge_cnt;
    logic [AW-1:0] m_mem_addr;

    function automatic void model_reset();
        m_pend = 2'b00; m_prev = 2'b00; m_en = 2'b00;
        m_addr[0] = '0; m_addr[1] = '0; m_rdata[0] = 8'h00; m_rdata[1] = 8'h00;
        m_last = 1; tx_active = 0; tx_accepted = 0; tx_owner = 0;
        tx_accept_edge = 0; edge_cnt = 0; m_mem_addr = '0;
    endfunction

    function automatic void model_edge();
        logic [1:0]    old_pend = m_pend;
        logic [1:0]    clr = 2'b00;
        logic [1:0]    rd;
        logic [AW-1:0] ain [2];
        logic [7:0]    reply = 8'h00;
        bit            fin = 0;
        rd = {b_rd, a_rd};
        ain[0] = a_address; ain[1] = b_address;
        edge_cnt++;
        m_en = 2'b00;
        if (tx_active && tx_accepted) begin
            if (mem_rdata_en) begin
                fin = 1; reply = mem_rdata;
            end else if (edge_cnt - tx_accept_edge == T) begin
                fin = 1; reply = 8'hFF;
            end
        end else if (tx_active) begin
            if (!mem_busy) begin
                tx_accepted = 1; tx_accept_edge = edge_cnt;
            end
        end else if (old_pend != 2'b00) begin
            if (old_pend == 2'b11) tx_owner = 1 - m_last;
            else tx_owner = old_pend[1] ? 1 : 0;
            tx_active = 1; tx_accepted = 0;
            m_mem_addr = m_addr[tx_owner];
        end
        if (fin) begin
            m_rdata[tx_owner] = reply;
            m_en[tx_owner] = 1'b1;
            clr[tx_owner] = 1'b1;
            m_last = tx_owner;
            tx_active = 0;
        end
        for (int c = 0; c < 2; c++) begin
            if (clr[c]) m_pend[c] = 1'b0;
            if (rd[c] && !m_prev[c] && (!old_pend[c] || clr[c])) begin
                m_pend[c] = 1'b1;
                m_addr[c] = ain[c];
            end
        end
        m_prev = rd;
    endfunction

    function automatic void check_model(input string name);
        logic emr = tx_active && !tx_accepted;
        vectors++;
        if ({a_busy, b_busy} !== {m_pend[0], m_pend[1]} ||
            {a_rdata_en, b_rdata_en} !== {m_en[0], m_en[1]} ||
            a_rdata !== m_rdata[0] || b_rdata !== m_rdata[1] ||
            mem_rd !== emr || mem_address !== m_mem_addr) begin
            errors++;
            show(name, {6'd0, a_busy, b_busy}, {6'd0, m_pend[0], m_pend[1]},
                 {6'd0, a_rdata_en, b_rdata_en}, {6'd0, m_en[0], m_en[1]},
                 a_rdata, m_rdata[0], b_rdata, m_rdata[1], mem_rd, emr,
                 mem_address, m_mem_addr);
        end
    endfunction

    // Inputs are already driven (we sit at a negedge); advance one edge and compare.
    task automatic tick(input string name);
        model_edge();
        @(negedge clk);
        check_model(name);
    endtask

    task automatic idle_inputs();
        a_rd = 0; b_rd = 0; a_address = '0; b_address = '0;
        mem_busy = 0; mem_rdata_en = 0; mem_rdata = 8'h00;
    endtask

    task automatic do_reset();
        @(negedge clk);
        n_reset = 0;
        idle_inputs();
        @(negedge clk);
        @(negedge clk);
        n_reset = 1;
        model_reset();
    endtask

    localparam logic [AW-1:0] PA = 22'h300000;
    localparam logic [AW-1:0] PB = 22'h010000;
    localparam logic [AW-1:0] PC = 22'h012345;

    initial begin
        int  n;
        bit  silent;
        n_reset = 0;
        idle_inputs();
        model_reset();
        repeat (2) @(negedge clk);
        vectors++;
        if ({a_busy, b_busy, a_rdata_en, b_rdata_en, a_rdata, b_rdata, mem_rd, mem_address} !== '0) begin
            errors++;
            $display("FAIL reset_state outputs got %h want 0",
                     {a_busy, b_busy, a_rdata_en, b_rdata_en, a_rdata, b_rdata, mem_rd, mem_address});
        end
        n_reset = 1;

        // Tie twice (A then B, then A again), followed by a lone A read with k=3.
        tbl.push_back(v(1,PA,1,PB,0,0,8'h00, 1,1,0,0,8'h00,8'h00,0,22'h0));
        tbl.push_back(v(1,PA,1,PB,0,0,8'h00, 1,1,0,0,8'h00,8'h00,1,PA));
        tbl.push_back(v(1,PA,1,PB,0,0,8'h00, 1,1,0,0,8'h00,8'h00,0,PA));
        tbl.push_back(v(1,PA,1,PB,0,1,8'hA1, 0,1,1,0,8'hA1,8'h00,0,PA));
        tbl.push_back(v(1,PA,1,PB,0,0,8'h00, 0,1,0,0,8'hA1,8'h00,1,PB));
        tbl.push_back(v(1,PA,1,PB,0,0,8'h00, 0,1,0,0,8'hA1,8'h00,0,PB));
        tbl.push_back(v(1,PA,1,PB,0,1,8'hB2, 0,0,0,1,8'hA1,8'hB2,0,PB));
        tbl.push_back(v(0,PA,0,PB,0,0,8'h00, 0,0,0,0,8'hA1,8'hB2,0,PB));
        tbl.push_back(v(1,PA,1,PB,0,0,8'h00, 1,1,0,0,8'hA1,8'hB2,0,PB));
        tbl.push_back(v(1,PA,1,PB,0,0,8'h00, 1,1,0,0,8'hA1,8'hB2,1,PA));
        tbl.push_back(v(1,PA,1,PB,0,0,8'h00, 1,1,0,0,8'hA1,8'hB2,0,PA));
        tbl.push_back(v(1,PA,1,PB,0,1,8'hC3, 0,1,1,0,8'hC3,8'hB2,0,PA));
        tbl.push_back(v(1,PA,1,PB,0,0,8'h00, 0,1,0,0,8'hC3,8'hB2,1,PB));
        tbl.push_back(v(1,PA,1,PB,0,0,8'h00, 0,1,0,0,8'hC3,8'hB2,0,PB));
        tbl.push_back(v(1,PA,1,PB,0,1,8'hD4, 0,0,0,1,8'hC3,8'hD4,0,PB));
        tbl.push_back(v(0,PA,0,PB,0,0,8'h00, 0,0,0,0,8'hC3,8'hD4,0,PB));
        tbl.push_back(v(1,PC,0,22'h0,0,0,8'h00, 1,0,0,0,8'hC3,8'hD4,0,PB));
        tbl.push_back(v(1,PC,0,22'h0,0,0,8'h00, 1,0,0,0,8'hC3,8'hD4,1,PC));
        tbl.push_back(v(1,PC,0,22'h0,0,0,8'h00, 1,0,0,0,8'hC3,8'hD4,0,PC));
        tbl.push_back(v(1,PC,0,22'h0,0,0,8'h00, 1,0,0,0,8'hC3,8'hD4,0,PC));
        tbl.push_back(v(1,PC,0,22'h0,0,0,8'h00, 1,0,0,0,8'hC3,8'hD4,0,PC));
        tbl.push_back(v(1,PC,0,22'h0,0,1,8'h5A, 0,0,1,0,8'h5A,8'hD4,0,PC));
        for (int i = 0; i < 4; i++)
            tbl.push_back(v(1,PC,0,22'h0,0,0,8'h00, 0,0,0,0,8'h5A,8'hD4,0,PC));
        tbl.push_back(v(0,PC,0,22'h0,0,0,8'h00, 0,0,0,0,8'h5A,8'hD4,0,PC));

        @(negedge clk);
        foreach (tbl[i]) begin
            a_rd = tbl[i].ard; a_address = tbl[i].aad;
            b_rd = tbl[i].brd; b_address = tbl[i].bad;
            mem_busy = tbl[i].busy; mem_rdata_en = tbl[i].en; mem_rdata = tbl[i].dat;
            @(negedge clk);
            vectors++;
            if ({a_busy, b_busy} !== {tbl[i].e_abusy, tbl[i].e_bbusy} ||
                {a_rdata_en, b_rdata_en} !== {tbl[i].e_aen, tbl[i].e_ben} ||
                a_rdata !== tbl[i].e_ard || b_rdata !== tbl[i].e_brd ||
                mem_rd !== tbl[i].e_mrd || mem_address !== tbl[i].e_maddr) begin
                errors++;
                show($sformatf("table[%0d]", i), {6'd0, a_busy, b_busy},
                     {6'd0, tbl[i].e_abusy, tbl[i].e_bbusy},
                     {6'd0, a_rdata_en, b_rdata_en}, {6'd0, tbl[i].e_aen, tbl[i].e_ben},
                     a_rdata, tbl[i].e_ard, b_rdata, tbl[i].e_brd,
                     mem_rd, tbl[i].e_mrd, mem_address, tbl[i].e_maddr);
            end
        end

        do_reset();

        // Controller busy for 20 cycles during ISSUE.
        a_rd = 1; a_address = 22'h2AAAAA; mem_busy = 1;
        tick("stall_rise");
        tick("stall_grant");
        for (int i = 0; i < 20; i++) tick("stall_hold");
        mem_busy = 0;
        tick("stall_accept");
        mem_rdata_en = 1; mem_rdata = 8'h3C;
        tick("stall_data");
        mem_rdata_en = 0; a_rd = 0;
        tick("stall_after");
        tick("stall_after");

        // Silent controller: forced 8'hFF exactly T cycles after accept.
        a_rd = 1; a_address = 22'h155555;
        tick("to_rise");
        tick("to_grant");
        tick("to_accept");
        n = 0;
        for (int i = 1; i <= T + 5; i++) begin
            tick("to_wait");
            if (a_rdata_en === 1'b1) begin
                n = i;
                break;
            end
        end
        vectors++;
        if (n != T || a_rdata !== 8'hFF) begin
            errors++;
            $display("FAIL timeout_latency got %0d cycles data %h want %0d cycles data ff",
                     n, a_rdata, T);
        end
        a_rd = 0; mem_rdata_en = 1; mem_rdata = 8'h11;
        tick("to_stray");
        mem_rdata_en = 0;
        tick("to_quiet");

        // rd held only one cycle still completes.
        a_rd = 1; a_address = 22'h000042;
        tick("short_rise");
        a_rd = 0;
        tick("short_grant");
        tick("short_accept");
        tick("short_wait");
        mem_rdata_en = 1; mem_rdata = 8'h99;
        tick("short_data");
        mem_rdata_en = 0;
        tick("short_after");

        // Reset while waiting for data.
        a_rd = 1; a_address = 22'h0ABCDE;
        tick("rst_rise");
        tick("rst_grant");
        tick("rst_accept");
        tick("rst_wait");
        #2 n_reset = 0;
        #1;
        vectors++;
        if ({a_busy, b_busy, a_rdata_en, b_rdata_en, a_rdata, b_rdata, mem_rd, mem_address} !== '0) begin
            errors++;
            $display("FAIL async_reset outputs got %h want 0",
                     {a_busy, b_busy, a_rdata_en, b_rdata_en, a_rdata, b_rdata, mem_rd, mem_address});
        end
        idle_inputs();
        model_reset();
        @(negedge clk);
        @(negedge clk);
        n_reset = 1;
        mem_rdata_en = 1; mem_rdata = 8'h77;
        tick("rst_late_en");
        mem_rdata_en = 0;
        a_rd = 1; a_address = 22'h3FFFFF;
        tick("rst_new_rise");
        tick("rst_new_grant");
        tick("rst_new_accept");
        mem_rdata_en = 1; mem_rdata = 8'hE7;
        tick("rst_new_data");
        mem_rdata_en = 0; a_rd = 0;
        tick("rst_new_after");

        // Randomized traffic against the model.
        silent = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (tx_active && tx_accepted && edge_cnt == tx_accept_edge)
                silent = ($urandom % 5 == 0);
            if ($urandom % 4 == 0) a_rd = ~a_rd;
            if ($urandom % 4 == 0) b_rd = ~b_rd;
            a_address = AW'($urandom);
            b_address = AW'($urandom);
            mem_busy  = ($urandom % 3 == 0);
            mem_rdata = 8'($urandom);
            if (tx_active && tx_accepted) mem_rdata_en = !silent && ($urandom % 4 == 0);
            else if (!tx_active)          mem_rdata_en = ($urandom % 8 == 0);
            else                          mem_rdata_en = 1'b0;
            tick("random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
